priority_decoder_32bit: RTL and testbench

Registered 5-to-32 decoder for the 32-bit priority encoder chain; it consumes the encoded index and turns it back into a one-hot, active-low request line.
Accepts the active-low code and group-select (gs_n) under a valid/ready handshake and buffers up to 2 codes in a FIFO.
Drives an active-low one-hot grant vector with valid/ready to the downstream consumer.
Sits on the receive side of the encoder chain and is the inverse of the encoder.

---
 rtl/priority_enc_pkg.sv | 19 +
 rtl/priority_decoder_32bit_decode_fifo.sv | 65 ++++++
 rtl/priority_decoder_32bit.sv | 74 +++++++
 tb/tb_priority_decoder_32bit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/priority_enc_pkg.sv
// Shared types and constants for the priority encoder/decoder chain.
// Provides the code width, the derived one-hot width, the stored entry type and the code->index helper.
package priority_enc_pkg;

    localparam int CODE_W = 5;
    localparam int OUT_W  = 2 ** CODE_W;

    typedef struct packed {
        logic              none;
        logic [CODE_W-1:0] idx;
    } dec_entry_t;

    function automatic logic [CODE_W-1:0] code_to_idx(
        input logic [CODE_W-1:0] code_n
    );
        return ~code_n;
    endfunction

endpackage

// File: rtl/priority_decoder_32bit_decode_fifo.sv
// decode_fifo: DEPTH-entry synchronous FIFO of dec_entry_t.
// Ports: clk, rst (sync, active-high), push/din, pop/head, full, empty, count.
module decode_fifo
    import priority_enc_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  dec_entry_t       din,
    input  logic             pop,
    output dec_entry_t       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    dec_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // Internal guards keep the FIFO consistent even if a caller ignores full/empty.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are log2(DEPTH) bits and wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/priority_decoder_32bit.sv
// Registered 5-to-32 decoder: buffers active-low codes and presents an active-low one-hot grant.
// Ports: clk, rst, en_n, in_valid/in_ready/code_n/gs_n, out_valid/out_ready/out_n, none_err, eo_n.
module priority_decoder_32bit
    import priority_enc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_n,
    input  logic              gs_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_n,
    output logic              none_err,
    output logic              eo_n
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    dec_entry_t       din;
    dec_entry_t       head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready depends only on registered state and en_n/rst, never on out_ready.
    assign in_ready  = ~rst & ~en_n & ~full;
    assign out_valid = ~en_n & ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign din.none = gs_n;
    assign din.idx  = code_to_idx(code_n);

    decode_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A none entry is still valid but drives no grant line.
    always_comb begin
        out_n = '1;
        if (out_valid && !head.none) begin
            out_n[head.idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            none_err <= 1'b0;
        end else if (push && gs_n) begin
            none_err <= 1'b1;
        end
    end

    // Cascade idle: enabled with nothing buffered.
    assign eo_n = ~(~en_n & (count == '0));

endmodule

// File: tb/tb_priority_decoder_32bit.sv
// Testbench for priority_decoder_32bit: directed scenarios plus random traffic.
// Outputs are compared every cycle against a queue-based reference model.
module tb_priority_decoder_32bit;
    import priority_enc_pkg::*;

    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_n;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] code_n;
    logic              gs_n;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_n;
    logic              none_err;
    logic              eo_n;

    int errors = 0;
    int checks = 0;

    dec_entry_t     q[$];
    bit             m_err;
    logic [31:0]    obs_out;
    logic           obs_ir;
    logic           obs_err;

    always #5 clk = ~clk;

    priority_decoder_32bit #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_n      (en_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_n    (code_n),
        .gs_n      (gs_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .none_err  (none_err),
        .eo_n      (eo_n)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare at negedge, advance the model at posedge.
    task automatic step(input bit r, input bit e, input bit v,
                        input logic [CODE_W-1:0] c, input bit g, input bit rdy);
        bit          x_ir;
        bit          x_ov;
        logic [31:0] x_out;
        dec_entry_t  ent;
        rst = r; en_n = e; in_valid = v; code_n = c; gs_n = g; out_ready = rdy;
        @(negedge clk);
        x_ir  = !r && !e && (q.size() < DEPTH);
        x_ov  = !e && (q.size() != 0);
        x_out = '1;
        if (x_ov && !q[0].none) x_out = ~(32'h1 << q[0].idx);
        check("in_ready", 32'(in_ready), 32'(x_ir));
        check("out_valid", 32'(out_valid), 32'(x_ov));
        check("out_n", out_n, x_out);
        check("none_err", 32'(none_err), 32'(m_err));
        check("eo_n", 32'(eo_n), 32'(!(!e && q.size() == 0)));
        obs_out = out_n;
        obs_ir  = in_ready;
        obs_err = none_err;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (x_ov && rdy) void'(q.pop_front());
            if (v && x_ir) begin
                ent.none = g;
                ent.idx  = ~c;
                q.push_back(ent);
                if (g) m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, '1, 0, rdy);
    endtask

    task automatic push_idx(input int idx, input bit rdy);
        step(0, 0, 1, ~CODE_W'(idx), 0, rdy);
    endtask

    initial begin
        rst = 1; en_n = 1; in_valid = 0; code_n = '1; gs_n = 0; out_ready = 0;
        m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 1, '0, 0, 1);

        // 1: single code, idx 3
        step(0, 0, 1, 5'b11100, 0, 1);
        idle(1);
        check("t1_out", obs_out, 32'hFFFF_FFF7);
        idle(1);

        // 2: fill with out_ready low, third held off
        push_idx(0, 0);
        push_idx(31, 0);
        push_idx(17, 0);
        check("t2_held", 32'(obs_ir), 32'h0);
        push_idx(17, 1);
        check("t2_a", obs_out, 32'hFFFF_FFFE);
        push_idx(17, 1);
        check("t2_b", obs_out, 32'h7FFF_FFFF);
        idle(1);
        check("t2_c", obs_out, 32'hFFFD_FFFF);
        idle(1);

        // 3: none entry
        step(0, 0, 1, 5'b11111, 1, 0);
        idle(1);
        check("t3_out", obs_out, 32'hFFFF_FFFF);
        idle(1);
        check("t3_sticky", 32'(obs_err), 32'h1);
        step(1, 0, 0, '1, 0, 0);
        idle(0);
        check("t3_clear", 32'(obs_err), 32'h0);

        // 4: streaming push+pop with one entry in flight
        push_idx(0, 0);
        for (int i = 1; i <= 10; i++) push_idx(i, 1);
        idle(1);
        idle(1);

        // 5: disable with two entries buffered
        push_idx(9, 0);
        push_idx(22, 0);
        repeat (3) step(0, 1, 1, 5'b00000, 0, 1);
        idle(0);
        check("t5_head", obs_out, 32'hFFFF_FDFF);
        idle(1);
        idle(1);

        // 6: reset while full
        push_idx(4, 0);
        step(0, 0, 1, 5'b11111, 1, 0);
        step(1, 0, 1, 5'b00000, 0, 1);
        push_idx(12, 1);
        check("t6_ready", 32'(obs_ir), 32'h1);
        idle(1);
        check("t6_out", obs_out, 32'hFFFF_EFFF);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 60),
                 CODE_W'($urandom),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 55));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
